// File: rtl/ddr_dmaster_rdylat_adt.sv
// Ready-latency adapter: accepts an upstream stream with ready latency L and
// re-presents it downstream with ready latency 0 through a small show-ahead buffer.
module ddr_dmaster_rdylat_adt #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned READY_LATENCY = 2,
    parameter int unsigned DEPTH         = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overflow
);
    localparam int unsigned L  = READY_LATENCY;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [L-1:0]      grant_hist;
    logic [CW-1:0]     count;
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [CW:0]       grants_pending;
    logic [CW:0]       outstanding;
    logic              granted_beat;
    logic              full;
    logic              push;
    logic              pop;

    // Every grant still in the history will land, so reserve space for all of them.
    always_comb begin
        grants_pending = '0;
        for (int unsigned i = 0; i < L; i++) begin
            grants_pending = grants_pending + (CW+1)'(grant_hist[i]);
        end
        outstanding = (CW+1)'(count) + grants_pending;
    end

    assign in_ready     = reset_n & (outstanding < (CW+1)'(DEPTH));
    assign out_valid    = reset_n & (count != '0);
    assign out_data     = mem[head];
    assign granted_beat = in_valid & grant_hist[L-1];
    assign full         = (count == CW'(DEPTH));
    assign pop          = out_valid & out_ready;
    assign push         = granted_beat & (~full | pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_hist <= '0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            overflow   <= 1'b0;
        end else begin
            grant_hist <= L'({grant_hist, in_ready});
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Ungranted beats and beats that find no room are dropped and flagged.
            if (in_valid & (~grant_hist[L-1] | (full & ~pop))) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_ddr_dmaster_rdylat_adt.sv
// Directed bench for ddr_dmaster_rdylat_adt (L=2, DEPTH=4, DATA_W=8) with a
// queue scoreboard holding the beats the buffer is expected to contain.
module tb_ddr_dmaster_rdylat_adt;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       overflow;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] popped[$];
    logic [1:0] m_g;
    logic       m_ovf;
    logic [7:0] next_data;
    logic       done;

    ddr_dmaster_rdylat_adt #(
        .DATA_W(8),
        .READY_LATENCY(2),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven: checks the
    // outputs, advances the reference state across the next rising edge.
    task automatic tick();
        logic        m_rdy;
        logic        m_valid;
        logic        m_pop;
        logic        m_push;
        int unsigned m_cnt;
        #1;
        m_cnt   = exp_q.size();
        m_rdy   = reset_n && ((m_cnt + m_g[0] + m_g[1]) < 4);
        m_valid = reset_n && (m_cnt != 0);
        chk("in_ready", in_ready, m_rdy);
        chk("out_valid", out_valid, m_valid);
        chk("overflow", overflow, m_ovf);
        chk("count", dut.count, m_cnt);
        if (m_valid) chk("out_data", out_data, exp_q[0]);
        if (!reset_n) begin
            exp_q.delete();
            m_g   = 2'b00;
            m_ovf = 1'b0;
        end else begin
            m_pop  = m_valid && out_ready;
            m_push = in_valid && m_g[1] && ((m_cnt < 4) || m_pop);
            if (in_valid && !m_push) m_ovf = 1'b1;
            if (m_pop) begin
                popped.push_back(out_data);
                exp_q.delete(0);
            end
            if (m_push) exp_q.push_back(in_data);
            m_g = {m_g[0], m_rdy};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compliant upstream: drives a beat exactly L cycles after each grant when send=1.
    task automatic up_cycles(input int unsigned n, input logic send);
        for (int unsigned i = 0; i < n; i++) begin
            in_valid = send && m_g[1];
            in_data  = in_valid ? next_data : 8'hEE;
            if (in_valid) next_data = next_data + 8'h01;
            tick();
        end
    endtask

    task automatic do_reset(input int unsigned n);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        m_g       = 2'b00;
        m_ovf     = 1'b0;
        next_data = 8'h00;
        done      = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held 3 cycles with a beat on the input
        for (int i = 0; i < 3; i++) tick();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        chk("r029_count", dut.count, 0);
        tick();

        // Streaming 0x01..0x08 with downstream always ready
        out_ready = 1'b1;
        next_data = 8'h01;
        popped.delete();
        for (int i = 0; i < 40 && next_data != 8'h09; i++) up_cycles(1, 1'b1);
        up_cycles(4, 1'b0);
        chk("r030_npop", popped.size(), 8);
        for (int k = 0; k < popped.size(); k++) chk("r030_order", popped[k], k + 1);
        chk("r030_ovf", overflow, 0);

        // Fill with downstream stalled, then drain
        do_reset(1);
        out_ready = 1'b0;
        next_data = 8'h10;
        popped.delete();
        up_cycles(8, 1'b1);
        chk("r031_full_count", dut.count, 4);
        chk("r031_rdy_low", in_ready, 0);
        out_ready = 1'b1;
        up_cycles(6, 1'b0);
        chk("r031_npop", popped.size(), 4);
        for (int k = 0; k < popped.size(); k++) chk("r031_order", popped[k], 8'h10 + k);
        chk("r031_ovf", overflow, 0);

        // Ungranted beat right after reset
        do_reset(1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        chk("r032_ovf_next", overflow, 1);
        out_ready = 1'b1;
        next_data = 8'h60;
        popped.delete();
        up_cycles(8, 1'b1);
        chk("r032_npop", popped.size() > 0, 1);
        for (int k = 0; k < popped.size(); k++) chk("r032_no55", popped[k] != 8'h55, 1);
        chk("r032_sticky", overflow, 1);
        do_reset(1);
        chk("r032_cleared", overflow, 0);

        // Simultaneous push and pop at count=3
        out_ready = 1'b0;
        next_data = 8'h30;
        popped.delete();
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            in_valid = m_g[1];
            in_data  = in_valid ? next_data : 8'hEE;
            if (in_valid) next_data = next_data + 8'h01;
            if (in_valid && exp_q.size() == 3) begin
                out_ready = 1'b1;
                done      = 1'b1;
            end
            tick();
            out_ready = 1'b0;
        end
        chk("r033_count", dut.count, 3);
        chk("r033_head", dut.head, 1);
        chk("r033_npop1", popped.size(), 1);
        out_ready = 1'b1;
        up_cycles(5, 1'b0);
        chk("r033_npop", popped.size(), 4);
        for (int k = 0; k < popped.size(); k++) chk("r033_order", popped[k], 8'h30 + k);

        // Reset with a grant in flight
        do_reset(1);
        out_ready = 1'b0;
        next_data = 8'h40;
        for (int i = 0; i < 20 && exp_q.size() != 3; i++) up_cycles(1, 1'b1);
        up_cycles(2, 1'b0);
        chk("r034_count3", dut.count, 3);
        chk("r034_inflight", dut.grant_hist, 2'b01);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        tick();
        reset_n  = 1'b1;
        chk("r034_cleared", dut.count, 0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        chk("r034_ovf", overflow, 1);
        chk("r034_empty", out_valid, 0);
        up_cycles(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
